// File: rtl/a0_trace_fifo.sv
// Change-detecting trace FIFO for the cpu's a0 register: pushes a0 whenever it differs from the
// last sampled value. Optional timestamping is enabled by defining A0_TRACE_TS_EN.
module a0_trace_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned TS_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   a0,
   input  logic                    capture_en,
   input  logic                    clear,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
`ifdef A0_TRACE_TS_EN
   output logic [TS_WIDTH-1:0]     out_ts,
`endif
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow,
   output logic [7:0]              drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_WIDTH < 1) begin : g_bad_param
      $error("a0_trace_fifo: DEPTH must be a power of two >= 2 and TS_WIDTH >= 1");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]           wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH-1:0] prev_a0_q;
   logic                  base_valid_q;
   logic                  overflow_q;
   logic [7:0]            drop_count_q;

   logic push_req, pop, full, push_ok, drop;

   always_comb begin
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      out_valid = (wr_ptr_q != rd_ptr_q);
      level     = wr_ptr_q - rd_ptr_q;
      push_req  = capture_en && (!base_valid_q || (a0 != prev_a0_q));
      pop       = out_valid && out_ready;
      // A pop on a full FIFO frees the slot the simultaneous push lands in.
      push_ok   = push_req && (!full || pop);
      drop      = push_req && full && !pop;
      out_data  = mem[rd_ptr_q[AW-1:0]];
      overflow   = overflow_q;
      drop_count = drop_count_q;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         base_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (capture_en) base_valid_q <= 1'b1;
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != 8'hff) drop_count_q <= drop_count_q + 8'd1;
         end
      end
   end

   // prev_a0 is meaningless while base_valid is low, so it needs no reset.
   always_ff @(posedge clk) begin
      if (capture_en) prev_a0_q <= a0;
   end

   always_ff @(posedge clk) begin
      if (push_ok && !rst && !clear) mem[wr_ptr_q[AW-1:0]] <= a0;
   end

`ifdef A0_TRACE_TS_EN
   logic [TS_WIDTH-1:0] ts_q;
   logic [TS_WIDTH-1:0] ts_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) ts_q <= '0;
      else     ts_q <= ts_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push_ok && !rst && !clear) ts_mem[wr_ptr_q[AW-1:0]] <= ts_q;
   end

   always_comb out_ts = ts_mem[rd_ptr_q[AW-1:0]];
`endif

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Directed self-checking bench for a0_trace_fifo (DEPTH=16); timestamp checks run only when
// A0_TRACE_TS_EN is defined, with TS_WIDTH=4 to exercise counter wrap.
module tb_a0_trace_fifo;

   localparam int unsigned DW = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned TSW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] a0 = '0;
   logic          capture_en = 1'b0;
   logic          clear = 1'b0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [4:0]    level;
   logic          overflow;
   logic [7:0]    drop_count;
`ifdef A0_TRACE_TS_EN
   logic [TSW-1:0] out_ts;
`endif

   int unsigned n_total = 0;
   int unsigned n_bad = 0;

   a0_trace_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .TS_WIDTH   (TSW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .a0         (a0),
      .capture_en (capture_en),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
`ifdef A0_TRACE_TS_EN
      .out_ts     (out_ts),
`endif
      .level      (level),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_vals(input int unsigned base, input int unsigned n);
      capture_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         a0 = base + i;
         step();
      end
      capture_en = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      step();
      step();
      check_eq("rst_level", level, 0);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_ovf", overflow, 0);
      check_eq("rst_drops", drop_count, 0);

`ifdef A0_TRACE_TS_EN
      // rst is sampled at the next edge; the cycle after it is cycle 0 with ts=0.
      step();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) step();
      capture_en = 1'b1;
      a0 = 42;
      step();
      capture_en = 1'b0;
      check_eq("ts_cycle7", out_ts, 7);
      for (int i = 0; i < 9; i++) step();
      capture_en = 1'b1;
      a0 = 43;
      step();
      capture_en = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq("ts_wrap_data", out_data, 43);
      check_eq("ts_wrap", out_ts, 1);
      do_clear();
`endif
      rst = 1'b0;

      // Constant a0: only the baseline capture is pushed.
      capture_en = 1'b1;
      a0 = 5;
      step();
      check_eq("const_first_level", level, 1);
      step();
      step();
      step();
      capture_en = 1'b0;
      check_eq("const_level", level, 1);
      check_eq("const_data", out_data, 5);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq("const_pop_level", level, 0);
      check_eq("const_pop_valid", out_valid, 0);

      // 1,2,2,3 -> three entries, popped in order.
      capture_en = 1'b1;
      a0 = 1; step();
      a0 = 2; step();
      a0 = 2; step();
      a0 = 3; step();
      capture_en = 1'b0;
      check_eq("seq_level", level, 3);
      out_ready = 1'b1;
      check_eq("seq_pop0", out_data, 1);
      step();
      check_eq("seq_pop1", out_data, 2);
      step();
      check_eq("seq_pop2", out_data, 3);
      step();
      out_ready = 1'b0;
      check_eq("seq_empty", level, 0);

      // DEPTH+3 distinct values -> 3 drops, first DEPTH retained.
      push_vals(100, DEPTH + 3);
      check_eq("ovf_level", level, DEPTH);
      check_eq("ovf_flag", overflow, 1);
      check_eq("ovf_drops", drop_count, 3);
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         check_eq($sformatf("ovf_order%0d", i), out_data, 100 + i);
         step();
      end
      out_ready = 1'b0;
      check_eq("ovf_drained", level, 0);
      check_eq("ovf_sticky", overflow, 1);
      do_clear();
      check_eq("clr_ovf", overflow, 0);
      check_eq("clr_drops", drop_count, 0);

      // Push while full with a simultaneous pop.
      push_vals(200, DEPTH);
      capture_en = 1'b1;
      out_ready = 1'b1;
      a0 = 216;
      step();
      capture_en = 1'b0;
      out_ready = 1'b0;
      check_eq("fullpop_level", level, DEPTH);
      check_eq("fullpop_ovf", overflow, 0);
      check_eq("fullpop_head", out_data, 201);
      do_clear();

      // Push and pop together on an empty FIFO: push only.
      capture_en = 1'b1;
      out_ready = 1'b1;
      a0 = 77;
      step();
      check_eq("emptypp_level", level, 1);
      check_eq("emptypp_data", out_data, 77);
      step();
      capture_en = 1'b0;
      out_ready = 1'b0;
      check_eq("emptypp_pop", level, 0);

      // clear beats a simultaneous capture; next unchanged capture is a baseline.
      push_vals(300, 5);
      check_eq("clr5_level", level, 5);
      capture_en = 1'b1;
      a0 = 999;
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_eq("clr5_after", level, 0);
      check_eq("clr5_valid", out_valid, 0);
      step();
      capture_en = 1'b0;
      check_eq("clr5_base_level", level, 1);
      check_eq("clr5_base_data", out_data, 999);
      do_clear();

      // drop_count saturates at 255.
      push_vals(1000, DEPTH + 260);
      check_eq("sat_drops", drop_count, 255);
      check_eq("sat_level", level, DEPTH);
      do_clear();

      // Reset mid-operation discards entries; next capture is a baseline.
      push_vals(400, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("mrst_level", level, 0);
      check_eq("mrst_valid", out_valid, 0);
      capture_en = 1'b1;
      a0 = 402;
      step();
      capture_en = 1'b0;
      check_eq("mrst_base_level", level, 1);
      check_eq("mrst_base_data", out_data, 402);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/a0_trace_fifo.md
A0_TRACE_FIFO -- requirements
Module: a0_trace_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of a0 samples and FIFO entries.
REQ-002 Parameter DEPTH, default 16, FIFO entries, power of two, at least 2.
REQ-003 Parameter TS_WIDTH, default 16, timestamp width; used only under A0_TRACE_TS_EN.
REQ-004 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1, reset; synchronous and active-high.
REQ-006 Port a0, input, DATA_WIDTH, register a0 value from the cpu top, sampled each cycle.
REQ-007 Port capture_en, input, 1, enables change detection and capture.
REQ-008 Port clear, input, 1, synchronous flush of the FIFO and status.
REQ-009 Port out_valid, output, 1, head entry available.
REQ-010 Port out_ready, input, 1, consumer accepts the head entry.
REQ-011 Port out_data, output, DATA_WIDTH, head entry's a0 value.
REQ-012 Port out_ts, output, TS_WIDTH, head entry's timestamp; present only under A0_TRACE_TS_EN.
REQ-013 Port level, output, log2(DEPTH)+1, current occupancy, 0..DEPTH.
REQ-014 Port overflow, output, 1, sticky flag set when a capture is dropped.
REQ-015 Port drop_count, output, 8, saturating count of dropped captures.

Function
REQ-016 Internal prev_a0 register and base_valid flag; capture_en=1 loads prev_a0<=a0 and sets base_valid.
REQ-017 A push is requested on a cycle with capture_en=1 and (base_valid=0 or a0!=prev_a0); capture_en=0 requests no push and freezes prev_a0.
REQ-018 FIFO is show-ahead: out_valid = (level!=0); out_data/out_ts reflect the oldest entry combinationally from storage.
REQ-019 Pop occurs when out_valid=1 and out_ready=1; out_ready while empty has no effect.
REQ-020 Latency: a push request in cycle N makes the entry visible in cycle N+1; out_valid on an empty FIFO rises in cycle N+1.
REQ-021 Read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full when the MSBs differ and the remaining bits are equal.
REQ-022 A push is accepted when not full, or when full and a pop occurs in the same cycle; level is then unchanged.
REQ-023 Push and pop in the same cycle on an empty FIFO: no pop occurs, the push is accepted, and level becomes 1.
REQ-024 A push request while full with no pop is dropped: overflow<=1, drop_count increments and saturates at 255, and FIFO contents are unchanged.
REQ-025 clear=1 has priority over push, pop and capture: level<=0, pointers<=0, overflow<=0, drop_count<=0, base_valid<=0; prev_a0 is don't-care.
REQ-026 out_data/out_ts are don't-care while out_valid=0.

Reset
REQ-027 rst=1 at a rising edge forces the same state as clear, and additionally clears the timestamp counter to 0.
REQ-028 Outputs during and after reset: out_valid=0, level=0, overflow=0, drop_count=0.
REQ-029 Reset asserted mid-operation discards all entries; the first capture after reset is a baseline push.

Configuration
REQ-030 Macro A0_TRACE_TS_EN defined: a free-running TS_WIDTH counter increments every cycle and wraps to 0; each entry stores the counter value of its push cycle; out_ts is present.
REQ-031 A0_TRACE_TS_EN undefined: there is no counter, no timestamp storage and no out_ts port; all other behaviour is identical.

Verification
REQ-032 rst then capture_en=1 with a0=5 constant for 4 cycles -> exactly one entry (5); level=1 on the cycle after the first capture.
REQ-033 a0 sequence 1,2,2,3 with out_ready=0 -> level=3; entries pop in order 1,2,3 when out_ready=1.
REQ-034 DEPTH+3 distinct values with out_ready=0 -> level=DEPTH, overflow=1, drop_count=3; the first DEPTH values are retained in order.
REQ-035 FIFO full with a new value and out_ready=1 in the same cycle -> head popped, new value accepted, level stays DEPTH, overflow stays 0.
REQ-036 clear=1 while level=5 and a new a0 value is present -> level=0 and out_valid=0 next cycle; the next change-free capture cycle pushes a baseline.
REQ-037 With A0_TRACE_TS_EN, after rst a change is pushed in cycle 7 after reset release -> out_ts=7; counter wrap at 2^TS_WIDTH is checked with TS_WIDTH=4.
